// File: rtl/cache2way_ctrl.sv
// Controller for a 2-way set-associative, write-back, write-allocate cache with
// one word per line; owns tag/valid/dirty/LRU state and the data store.
module cache2way_ctrl #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INDEX_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              hit,
    output logic              miss,
    output logic              dirty1,
    output logic              dirty2,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W;
    localparam int unsigned SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StFill, StDone} state_e;

    state_e r_state, w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic              r_wren;
    logic [DATA_W-1:0] r_wdata;
    logic              r_victim;
    logic [DATA_W-1:0] r_rdata;
    logic              r_hit, r_miss, r_dirty1, r_dirty2;

    logic [TAG_W-1:0]  r_tag   [2][SETS];
    logic [DATA_W-1:0] r_data  [2][SETS];
    logic [SETS-1:0]   r_valid [2];
    logic [SETS-1:0]   r_dirty [2];
    logic [SETS-1:0]   r_lru;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit0, w_hit1, w_hit, w_hit_way;
    logic               w_vict, w_vict_dirty;
    logic [DATA_W-1:0]  w_fill_data;

    assign w_idx        = r_addr[INDEX_W-1:0];
    assign w_tag        = r_addr[ADDR_W-1:INDEX_W];
    assign w_hit0       = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1       = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit        = w_hit0 || w_hit1;
    assign w_hit_way    = !w_hit0;
    // Empty ways are filled before anything is evicted, way 0 first.
    assign w_vict       = !r_valid[0][w_idx] ? 1'b0 :
                          !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_vict_dirty = r_valid[w_vict][w_idx] && r_dirty[w_vict][w_idx];
    assign w_fill_data  = r_wren ? r_wdata : mem_rdata;

    always_ff @(posedge clock) begin
        if (!resetn) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:      if (cpu_req) w_state_next = StLookup;
            StLookup:    w_state_next = w_hit ? StDone : (w_vict_dirty ? StWriteback : StFill);
            StWriteback: if (mem_ack) w_state_next = StFill;
            StFill:      if (mem_ack) w_state_next = StDone;
            StDone:      w_state_next = StIdle;
            default:     w_state_next = StIdle;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            StWriteback: begin
                mem_req   = 1'b1;
                mem_wren  = 1'b1;
                mem_addr  = {r_tag[r_victim][w_idx], w_idx};
                mem_wdata = r_data[r_victim][w_idx];
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
            end
            StDone:  cpu_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_addr   <= '0;
            r_wren   <= 1'b0;
            r_wdata  <= '0;
            r_victim <= 1'b0;
            r_rdata  <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_dirty1 <= 1'b0;
            r_dirty2 <= 1'b0;
            r_lru    <= '0;
            for (int w = 0; w < 2; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
                for (int s = 0; s < SETS; s++) begin
                    r_tag[w][s]  <= '0;
                    r_data[w][s] <= '0;
                end
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_wren  <= cpu_wren;
                        r_wdata <= cpu_wdata;
                    end
                end
                StLookup: begin
                    r_hit    <= w_hit;
                    r_miss   <= !w_hit;
                    r_victim <= w_vict;
                    // Status reflects the set after a write hit marks its way dirty.
                    r_dirty1 <= r_dirty[0][w_idx] | (w_hit & r_wren & !w_hit_way);
                    r_dirty2 <= r_dirty[1][w_idx] | (w_hit & r_wren & w_hit_way);
                    if (w_hit) begin
                        r_lru[w_idx] <= !w_hit_way;
                        if (r_wren) begin
                            r_data[w_hit_way][w_idx]  <= r_wdata;
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                            r_rdata                   <= r_wdata;
                        end else begin
                            r_rdata <= r_data[w_hit_way][w_idx];
                        end
                    end
                end
                StFill: begin
                    if (mem_ack) begin
                        r_data[r_victim][w_idx]  <= w_fill_data;
                        r_tag[r_victim][w_idx]   <= w_tag;
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= r_wren;
                        r_rdata                  <= w_fill_data;
                        r_lru[w_idx]             <= !r_victim;
                        r_dirty1 <= r_victim ? r_dirty[0][w_idx] : r_wren;
                        r_dirty2 <= r_victim ? r_wren : r_dirty[1][w_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_rdata = r_rdata;
    assign hit       = r_hit;
    assign miss      = r_miss;
    assign dirty1    = r_dirty1;
    assign dirty2    = r_dirty2;

endmodule

// File: tb/tb_cache2way_ctrl.sv
// Randomised bench for cache2way_ctrl: a recency-list cache model plus a word-array
// backing memory predict hit/data/status and the exact memory phase sequence.
module tb_cache2way_ctrl;
    logic       clock = 1'b0;
    logic       resetn;
    logic       cpu_req, cpu_wren;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       cpu_ready, hit, miss, dirty1, dirty2;
    logic       mem_req, mem_wren;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_ack;

    cache2way_ctrl #(.ADDR_W(5), .DATA_W(8), .INDEX_W(2)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .hit(hit), .miss(miss), .dirty1(dirty1), .dirty2(dirty2),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: backing memory, per-set lines and the most-recently-used way.
    logic [7:0] mem_model [32];
    bit         m_valid [4][2];
    bit         m_dirty [4][2];
    logic [2:0] m_tag   [4][2];
    logic [7:0] m_data  [4][2];
    int         m_mru   [4];

    typedef struct {bit wr; logic [4:0] a; logic [7:0] d;} phase_t;
    phase_t exp_ph[$];

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; m_data[s][w] = '0;
            end
            m_mru[s] = 1;  // cleared LRU bit names way 0 as least recent
        end
    endtask

    task automatic model_access(input bit wr, input logic [4:0] a, input logic [7:0] wd,
                                output bit ehit, output logic [7:0] erd,
                                output bit ed1, output bit ed2);
        logic [1:0] s;
        logic [2:0] t;
        int         w;
        phase_t     p;
        s = a[1:0];
        t = a[4:2];
        w = -1;
        exp_ph.delete();
        for (int i = 0; i < 2; i++)
            if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) w = i;
        ehit = (w >= 0);
        if (!ehit) begin
            if (!m_valid[s][0])      w = 0;
            else if (!m_valid[s][1]) w = 1;
            else                     w = 1 - m_mru[s];
            if (m_valid[s][w] && m_dirty[s][w]) begin
                p.wr = 1; p.a = {m_tag[s][w], s}; p.d = m_data[s][w];
                exp_ph.push_back(p);
                mem_model[p.a] = p.d;
            end
            p.wr = 0; p.a = a; p.d = '0;
            exp_ph.push_back(p);
            m_data[s][w]  = mem_model[a];
            m_tag[s][w]   = t;
            m_valid[s][w] = 1;
            m_dirty[s][w] = 0;
        end
        if (wr) begin
            m_data[s][w]  = wd;
            m_dirty[s][w] = 1;
        end
        erd    = m_data[s][w];
        m_mru[s] = w;
        ed1    = m_dirty[s][0];
        ed2    = m_dirty[s][1];
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
        check_eq({tag, "_ctl"},
                 32'({cpu_ready, hit, miss, dirty1, dirty2, mem_req, mem_wren}), 32'd0);
        check_eq({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // delay < 0 picks a random ack delay (0..3 cycles) per memory phase.
    task automatic access(input bit wr, input logic [4:0] a, input logic [7:0] wd,
                          input int delay);
        bit         ehit, ed1, ed2;
        logic [7:0] erd;
        int         ph, wait_c, last_ack, ready_c, dly;
        model_access(wr, a, wd, ehit, erd, ed1, ed2);
        ph = 0; wait_c = 0; last_ack = -10; ready_c = -1;
        dly = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
        @(negedge clock);
        cpu_req = 1; cpu_wren = wr; cpu_addr = a; cpu_wdata = wd;
        @(negedge clock);
        cpu_req = 0; cpu_wren = 1'($urandom); cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
        for (int c = 1; c <= 60 && ready_c < 0; c++) begin
            mem_ack = 0;
            if (cpu_ready) begin
                ready_c = c;
            end else if (mem_req) begin
                if (ph >= exp_ph.size()) begin
                    check_eq("extra_mem_phase", 32'(ph), 32'(exp_ph.size()));
                    break;
                end
                check_eq("mem_wren", 32'(mem_wren), 32'(exp_ph[ph].wr));
                check_eq("mem_addr", 32'(mem_addr), 32'(exp_ph[ph].a));
                if (exp_ph[ph].wr) check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_ph[ph].d));
                if (wait_c == dly) begin
                    mem_ack   = 1;
                    mem_rdata = mem_model[mem_addr];
                    last_ack  = c;
                    ph++;
                    wait_c = 0;
                    dly = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
                end else begin
                    wait_c++;
                end
            end
            if (ready_c < 0) @(negedge clock);
        end
        mem_ack = 0;
        check_eq("ready_timeout", 32'(ready_c > 0), 32'd1);
        if (ready_c < 0) return;
        check_eq("hit", 32'(hit), 32'(ehit));
        check_eq("miss", 32'(miss), 32'(!ehit));
        check_eq("cpu_rdata", 32'(cpu_rdata), 32'(erd));
        check_eq("dirty1", 32'(dirty1), 32'(ed1));
        check_eq("dirty2", 32'(dirty2), 32'(ed2));
        check_eq("mem_phases", 32'(ph), 32'(exp_ph.size()));
        check_eq("mem_req_done", 32'(mem_req), 32'd0);
        if (ehit) check_eq("hit_latency", 32'(ready_c), 32'd2);
        else      check_eq("miss_latency", 32'(ready_c), 32'(last_ack + 1));
        @(negedge clock);
        check_eq("ready_pulse", 32'(cpu_ready), 32'd0);
        check_eq("hit_hold", 32'(hit), 32'(ehit));
    endtask

    initial begin
        int waited;
        resetn = 0; cpu_req = 0; cpu_wren = 0; cpu_addr = '0; cpu_wdata = '0;
        mem_rdata = '0; mem_ack = 0;
        for (int i = 0; i < 32; i++) mem_model[i] = 8'($urandom);
        mem_model[5'h05] = 8'hA5;
        mem_model[5'h09] = 8'h99;
        mem_model[5'h1E] = 8'h00;
        model_reset();
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        resetn = 1;

        access(0, 5'h05, 8'h00, 3);
        access(0, 5'h05, 8'h00, -1);
        access(1, 5'h05, 8'h3C, -1);
        access(0, 5'h05, 8'h00, -1);
        access(0, 5'h01, 8'h00, 0);
        access(0, 5'h09, 8'h00, -1);
        access(1, 5'h1E, 8'h77, -1);
        access(0, 5'h1E, 8'h00, -1);

        // Abandon a fill by pulsing reset while mem_ack is withheld.
        @(negedge clock);
        cpu_req = 1; cpu_wren = 0; cpu_addr = 5'h12;
        @(negedge clock);
        cpu_req = 0;
        waited = 0;
        while (!mem_req && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        repeat (2) @(negedge clock);
        check_eq("fill_held", 32'(mem_req), 32'd1);
        resetn = 0;
        @(negedge clock);
        check_reset_outputs("midreset");
        resetn = 1;
        model_reset();
        access(0, 5'h05, 8'h00, -1);
        check_eq("post_reset_miss", 32'(miss), 32'd1);

        for (int n = 0; n < 150; n++)
            access(1'($urandom), 5'($urandom_range(0, 31)), 8'($urandom), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache2way_ctrl.md
# cache2way_ctrl

Sequencing controller for the 2-way set-associative, write-back, write-allocate 8-bit cache on the board-level datapath. It owns the tag, valid, dirty and LRU state plus the 8-byte data store. It accepts single-word CPU requests and drives a request/acknowledge backing-memory port for victim write-back and line fill. It also produces the hit, miss and dirty status shown on the LEDG indicators.

## Interface
Parameters:
- ADDR_W, 5, CPU and memory word address width; tag = addr[4:2], index = addr[1:0]
- DATA_W, 8, data word width
- INDEX_W, 2, set index width (4 sets × 2 ways, one word per line)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_wren  in  1  1 = write, 0 = read; latched with cpu_req
- cpu_addr  in  5  word address; latched with cpu_req
- cpu_wdata  in  8  write data; latched with cpu_req
- cpu_rdata  out  8  read data; valid while cpu_ready = 1
- cpu_ready  out  1  one-cycle completion pulse
- hit  out  1  last lookup hit (registered)
- miss  out  1  last lookup missed (registered)
- dirty1  out  1  dirty bit of way 0 of the last accessed set
- dirty2  out  1  dirty bit of way 1 of the last accessed set
- mem_req  out  1  memory request; held until acknowledged
- mem_wren  out  1  1 = write-back, 0 = fill read
- mem_addr  out  5  memory word address
- mem_wdata  out  8  write-back data
- mem_rdata  in  8  fill data; sampled on the mem_ack cycle
- mem_ack  in  1  memory completion; ignored while mem_req = 0

## Operation
- States:
  - IDLE → LOOKUP when cpu_req = 1. Latch addr, wren and wdata. cpu_req is ignored in every other state.
  - LOOKUP, 1 cycle:
    - Compare the latched tag against both ways of the set.
    - hit = valid & tag match. Update the hit and miss registers. Update dirty1 and dirty2 from the set.
    - On a hit:
      - Read: cpu_rdata ← way data.
      - Write: way data ← wdata, way dirty ← 1, cpu_rdata ← wdata.
      - LRU ← the other way. Go to DONE.
    - On a miss, choose the victim:
      - If there is an invalid way, take it (way 0 preferred). Otherwise take the LRU way.
      - If the victim is valid and dirty, go to WRITEBACK. Otherwise go to FILL.
  - WRITEBACK:
    - Drive mem_req = 1, mem_wren = 1, mem_addr = {victim tag, index}, mem_wdata = victim data.
    - On mem_ack, go to FILL.
  - FILL:
    - Drive mem_req = 1, mem_wren = 0, mem_addr = latched addr.
    - On mem_ack, install the line in the victim way: data ← mem_rdata, tag ← latched tag, valid ← 1, dirty ← 0.
    - If wren, merge the write: data ← wdata, dirty ← 1.
    - Set cpu_rdata to the final line data. LRU ← the other way. Refresh dirty1 and dirty2. Go to DONE.
  - DONE: cpu_ready = 1 for exactly one cycle, then IDLE.
- LRU: one bit per set, naming the least-recently-used way. Every completed access makes the touched way most-recently-used.
- A write miss never issues a memory write for the new data. Memory is written only on eviction of a dirty line.

## Timing
- Reset (resetn = 0 at an edge):
  - State → IDLE.
  - All valid, dirty and LRU bits and the data store → 0.
  - cpu_rdata = 0; cpu_ready, hit, miss, dirty1, dirty2, mem_req, mem_wren = 0; mem_addr = 0; mem_wdata = 0.
- Reset mid-operation: at the next edge the in-flight transaction is abandoned and mem_req drops. The memory side must tolerate the dropped request.
- Hit latency: the request is sampled at edge 0. LOOKUP runs in cycle 1. cpu_ready is high in cycle 2. No mem_req is issued.
- Miss latency: cpu_ready is high in the cycle after the FILL mem_ack cycle.
- mem_req, mem_wren, mem_addr and mem_wdata are stable from entry into WRITEBACK or FILL until the ack edge.
- mem_ack may arrive in the first cycle of the request, giving a minimum of 1 cycle per memory phase.
- WRITEBACK → FILL inserts no idle cycle. mem_req stays high and mem_wren falls.
- hit, miss, dirty1 and dirty2 hold their values until the next LOOKUP or FILL completion.

## Test plan
- Reset, then read 0x05 with memory returning 0xA5 after a 3-cycle ack delay:
  - miss = 1, one mem_req with mem_wren = 0 and mem_addr = 0x05.
  - cpu_rdata = 0xA5, dirty1 = 0.
- Read 0x05 again:
  - hit = 1, cpu_ready exactly 2 cycles after the request edge, mem_req stays 0, cpu_rdata = 0xA5.
- Write 0x05 with 0x3C:
  - hit = 1, dirty1 = 1, no memory traffic.
  - A following read of 0x05 returns 0x3C.
- Read 0x01, which fills way 1 (dirty2 = 0). Then read 0x09 with memory returning 0x99:
  - Way 0 is evicted, giving a write-back with mem_addr = 0x05, mem_wdata = 0x3C.
  - Then a fill with mem_addr = 0x09. cpu_rdata = 0x99, dirty1 = 0.
- Write miss to 0x1E with 0x77, memory returning 0x00:
  - Only a fill is issued (mem_wren never 1).
  - A following read of 0x1E hits and returns 0x77; dirty flag for its way = 1.
- Request read 0x12 and hold mem_ack low in FILL, then pulse resetn low for 1 cycle:
  - mem_req = 0 at the next edge, all outputs at reset values.
  - A read of 0x05 then misses.
